// File: rtl/bpred_pkg.sv
// Shared constants and helpers for the dynamic branch predictor.
// Provides counter defaults, saturating arithmetic and index-width derivation.
package bpred_pkg;

   localparam int CNT_W_DEF = 2;

   // Weakly not-taken: one below the taken threshold.
   function automatic int cnt_init(input int w);
      return (2 ** (w - 1)) - 1;
   endfunction

   localparam int CNT_INIT_DEF = cnt_init(CNT_W_DEF);

   function automatic int idx_w(input int entries);
      return $clog2(entries);
   endfunction

   function automatic logic [31:0] cnt_max(input int w);
      return (w >= 32) ? 32'hFFFF_FFFF : 32'((64'd1 << w) - 64'd1);
   endfunction

   function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] vmax);
      return (v >= vmax) ? vmax : v + 32'd1;
   endfunction

   function automatic logic [31:0] sat_dec(input logic [31:0] v);
      return (v == 32'd0) ? 32'd0 : v - 32'd1;
   endfunction

endpackage

// File: rtl/sat_counter_table.sv
// Table of saturating counters with one train port and one combinational read port.
// Index hashing is left to the caller so a gshare variant can reuse this unchanged.
module sat_counter_table
   import bpred_pkg::*;
#(
   parameter int ENTRIES  = 256,
   parameter int CNT_W    = CNT_W_DEF,
   parameter int CNT_INIT = cnt_init(CNT_W),
   localparam int IDX_W   = idx_w(ENTRIES)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_trn_en,
   input  logic [IDX_W-1:0] i_trn_idx,
   input  logic             i_trn_taken,
   input  logic [IDX_W-1:0] i_rd_idx,
   output logic [CNT_W-1:0] o_rd_cnt
);

   localparam logic [31:0] CNT_MAX = cnt_max(CNT_W);

   logic [CNT_W-1:0] r_cnt [ENTRIES];
   logic [CNT_W-1:0] w_cur;
   logic [CNT_W-1:0] w_nxt;

   assign w_cur    = r_cnt[i_trn_idx];
   assign w_nxt    = i_trn_taken ? CNT_W'(sat_inc(32'(w_cur), CNT_MAX))
                                 : CNT_W'(sat_dec(32'(w_cur)));
   assign o_rd_cnt = r_cnt[i_rd_idx];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ENTRIES; i++) r_cnt[i] <= CNT_W'(CNT_INIT);
      end else if (i_trn_en) begin
         r_cnt[i_trn_idx] <= w_nxt;
      end
   end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB plus separately indexed BHT; IF lookup and EX training/redirect.
// Optional BPRED_PERF_CNT_EN adds saturating update/mispredict counters.
module branch_predictor
   import bpred_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int BTB_ENTRIES = 64,
   parameter int BHT_ENTRIES = 256,
   parameter int CNT_W       = CNT_W_DEF,
   parameter int CNT_INIT    = cnt_init(CNT_W)
) (
   input  logic              clk,
   input  logic              rst_n,
`ifdef BPRED_PERF_CNT_EN
   output logic [31:0]       br_count,
   output logic [31:0]       mispred_count,
`endif
   input  logic [ADDR_W-1:0] if_pc,
   output logic              pred_taken,
   output logic [ADDR_W-1:0] pred_target,
   input  logic              upd_valid,
   input  logic              upd_is_br,
   input  logic [ADDR_W-1:0] upd_pc,
   input  logic              upd_taken,
   input  logic [ADDR_W-1:0] upd_target,
   input  logic              upd_pred_taken,
   input  logic [ADDR_W-1:0] upd_pred_target,
   output logic              mispredict,
   output logic [ADDR_W-1:0] redirect_pc
);

   localparam int BTB_IW = idx_w(BTB_ENTRIES);
   localparam int BHT_IW = idx_w(BHT_ENTRIES);
   localparam int TAG_W  = ADDR_W - BTB_IW - 2;

   logic [BTB_ENTRIES-1:0] r_valid;
   logic [TAG_W-1:0]       r_tag [BTB_ENTRIES];
   logic [ADDR_W-1:0]      r_tgt [BTB_ENTRIES];

   logic [BTB_IW-1:0] w_if_btb_idx;
   logic [TAG_W-1:0]  w_if_tag;
   logic [BTB_IW-1:0] w_up_btb_idx;
   logic [TAG_W-1:0]  w_up_tag;
   logic              w_hit;
   logic [CNT_W-1:0]  w_rd_cnt;
   logic [ADDR_W-1:0] w_if_plus4;
   logic              w_pred_tk;
   logic              w_btb_wr;
   logic              w_mispred;
   logic              w_unused;

   assign w_if_btb_idx = if_pc[BTB_IW+1:2];
   assign w_if_tag     = if_pc[ADDR_W-1:BTB_IW+2];
   assign w_up_btb_idx = upd_pc[BTB_IW+1:2];
   assign w_up_tag     = upd_pc[ADDR_W-1:BTB_IW+2];
   assign w_unused     = ^{if_pc[1:0], upd_pc[1:0], w_rd_cnt};

   // ---------------- Lookup (IF) ----------------
   // Reads pre-edge state; a same-cycle update is visible only next cycle.
   assign w_hit       = r_valid[w_if_btb_idx] && (r_tag[w_if_btb_idx] == w_if_tag);
   assign w_if_plus4  = if_pc + ADDR_W'(4);
   assign w_pred_tk   = rst_n && w_hit && w_rd_cnt[CNT_W-1];
   assign pred_taken  = w_pred_tk;
   assign pred_target = w_pred_tk ? r_tgt[w_if_btb_idx] : w_if_plus4;

   sat_counter_table #(
      .ENTRIES  (BHT_ENTRIES),
      .CNT_W    (CNT_W),
      .CNT_INIT (CNT_INIT)
   ) u_bht (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_trn_en    (upd_valid && upd_is_br),
      .i_trn_idx   (upd_pc[BHT_IW+1:2]),
      .i_trn_taken (upd_taken),
      .i_rd_idx    (if_pc[BHT_IW+1:2]),
      .o_rd_cnt    (w_rd_cnt)
   );

   // ---------------- BTB training (EX) ----------------
   // Only taken outcomes allocate; aliasing entries are simply overwritten.
   assign w_btb_wr = upd_valid && upd_taken;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= '0;
      end else if (w_btb_wr) begin
         r_valid[w_up_btb_idx] <= 1'b1;
      end
   end

   // Tag/target need no reset: they are never observed while the valid bit is clear.
   always_ff @(posedge clk) begin
      if (w_btb_wr) begin
         r_tag[w_up_btb_idx] <= w_up_tag;
         r_tgt[w_up_btb_idx] <= upd_target;
      end
   end

   // ---------------- Misprediction / redirect ----------------
   assign w_mispred = rst_n && upd_valid &&
                      ((upd_pred_taken != upd_taken) ||
                       (upd_taken && (upd_pred_target != upd_target)));
   assign mispredict  = w_mispred;
   assign redirect_pc = upd_taken ? upd_target : (upd_pc + ADDR_W'(4));

`ifdef BPRED_PERF_CNT_EN
   logic [31:0] r_br_cnt;
   logic [31:0] r_mp_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_br_cnt <= '0;
         r_mp_cnt <= '0;
      end else begin
         if (upd_valid && (r_br_cnt != 32'hFFFF_FFFF)) r_br_cnt <= r_br_cnt + 32'd1;
         if (w_mispred && (r_mp_cnt != 32'hFFFF_FFFF)) r_mp_cnt <= r_mp_cnt + 32'd1;
      end
   end

   assign br_count      = r_br_cnt;
   assign mispred_count = r_mp_cnt;
`endif

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Parametrised dynamic branch predictor; successor to the core's static next-PC path (jal resolved in ID, br/jalr in EX).
- Direct-mapped BTB (tag, target, valid) plus a separately indexed BHT of saturating counters.
- IF-stage lookup gives predicted next PC in the same cycle.
- EX-stage update trains the tables and flags mispredictions so the hazard unit can flush IF/ID and redirect the PC.

Parameters:
- ADDR_W, 32, PC/target width.
- BTB_ENTRIES, 64, BTB entries; power of 2, ≥2.
- BHT_ENTRIES, 256, BHT counters; power of 2, ≥2.
- CNT_W, 2, saturating counter width; ≥1.
- CNT_INIT, 2**(CNT_W-1)-1, counter reset value (weakly not-taken).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_pc  in  ADDR_W  PC of the instruction being fetched.
- pred_taken  out  1  predicted taken for if_pc.
- pred_target  out  ADDR_W  predicted next PC (BTB target if pred_taken, else if_pc+4).
- upd_valid  in  1  EX holds a resolved control-transfer instruction (0 while bubbled/flushed).
- upd_is_br  in  1  conditional branch (1) vs jalr (0).
- upd_pc  in  ADDR_W  PC of the resolved instruction.
- upd_taken  in  1  actual outcome.
- upd_target  in  ADDR_W  actual target.
- upd_pred_taken  in  1  prediction carried down the pipe.
- upd_pred_target  in  ADDR_W  predicted next PC carried down the pipe.
- mispredict  out  1  redirect required this cycle.
- redirect_pc  out  ADDR_W  correct next PC.

Behaviour:
- Index/tag:
  - btb_idx = pc[log2(BTB_ENTRIES)+1:2]; tag = pc[ADDR_W-1:log2(BTB_ENTRIES)+2].
  - bht_idx = pc[log2(BHT_ENTRIES)+1:2].
- Lookup (combinational, zero latency):
  - hit = valid[btb_idx] && tag match.
  - pred_taken = hit && counter[bht_idx][CNT_W-1].
  - pred_target = pred_taken ? btb_target : if_pc+4, computed modulo 2^ADDR_W (if_pc = 0xFFFFFFFC gives 0x00000000).
- Update (clock edge, only when upd_valid=1):
  - Counter training, when upd_is_br: saturating +1 if taken, -1 if not taken. No wrap: stays at 2^CNT_W-1 and at 0.
  - jalr does not touch the BHT; its BTB entry is predicted via the counter at its bht_idx.
  - BTB write, when upd_taken: valid=1, tag, and target written at upd_pc's btb_idx, overwriting any aliased entry.
  - Not-taken outcomes never allocate and never invalidate.
- Misprediction (combinational from upd_*):
  - mispredict = upd_valid && ((upd_pred_taken != upd_taken) || (upd_taken && upd_pred_target != upd_target)).
  - redirect_pc = upd_taken ? upd_target : upd_pc+4.
  - mispredict=0 whenever upd_valid=0.
- Simultaneous lookup and update to the same index: lookup returns pre-edge contents (no write-through bypass).
- Reset (asynchronous assert, synchronous-safe release):
  - All valid bits 0; all counters = CNT_INIT; tags/targets don't-care.
  - Outputs during reset: pred_taken=0, pred_target=if_pc+4, mispredict=0 (gated by rst_n).
  - Reset mid-operation discards all learned state; no partial update completes.
- No internal stall input: the pipeline deasserts upd_valid for bubbled or flushed EX contents.

Optional Feature:
- Macro: BPRED_PERF_CNT_EN.
- When defined, adds two outputs, each reset to 0 and saturating at 0xFFFFFFFF:
  - br_count (32) increments on every upd_valid.
  - mispred_count (32) increments on every mispredict.
- When undefined, these ports and their registers do not exist; all other behaviour is identical.

Decomposition:
- Shared package bpred_pkg:
  - CNT_W default; CNT_INIT.
  - Counter saturate-increment/decrement functions.
  - Index/tag width derivation constants (log2 helpers).
- One sub-module: sat_counter_table (BHT_ENTRIES x CNT_W array with train port and read port), reusable for a future gshare variant.
- BTB stays inline.

Test Plan:
- Reset then lookup if_pc=0x100 → pred_taken=0, pred_target=0x104; mispredict=0 with upd_valid=0.
- Branch at 0x200, target 0x280, resolved taken twice (CNT_W=2: 1→2→3):
  - 1st update: upd_pred_taken=0 → mispredict=1, redirect_pc=0x280.
  - Next cycle lookup 0x200 → pred_taken=1, pred_target=0x280.
- Counter saturation: six taken then one not-taken at 0x300 → counter 3→2, still pred_taken=1. Two more not-taken → 0; further not-taken stays 0, pred_taken=0.
- Alias (BTB_ENTRIES=64): taken branch 0x400→0x500, then taken 0x500 (same btb_idx)→0x600. Lookup 0x400 → tag miss, pred_taken=0.
- Same-cycle update and lookup at 0x200 for its first taken update → lookup shows old state (pred_taken=0); following cycle pred_taken=1.
- With BPRED_PERF_CNT_EN: 10 updates, 3 mispredicted → br_count=10, mispred_count=3. Assert rst_n low mid-stream → both 0 immediately.
